// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter and sequencer that shares one SPI master
// IP register port between two byte-transfer requesters. Each grant runs the
// sequence: select slave, poll TX ready, write TX byte, poll RX ready, read RX
// byte, deselect. The winner then gets a one-cycle ack, or a one-cycle err if a
// poll phase times out.
//
// Ports:
//   I_CLK, I_RESETN        clock, asynchronous active-low reset
//   I_REQ[1:0]             per-requester request level (held until ack/err)
//   I_REQn_DATA, I_REQn_SS byte to send and slave-select mask per requester
//   O_ACK, O_ERR           one-cycle done / timeout pulse per requester
//   O_RX_DATA              received byte, updated only on a completed transfer
//   O_BUSY                 high from grant+1 through the DONE/ERR cycle
//   O_TX_EN/O_WADDR/O_WDATA  IP register write strobe, address, data
//   O_RX_EN/O_RADDR        IP register read strobe, address
//   I_RDATA                IP read data, valid one cycle after O_RX_EN
module spi_xfer_arbiter #(
  parameter int unsigned DW          = 8,
  parameter logic [2:0]  ADDR_RXDATA = 3'd0,
  parameter logic [2:0]  ADDR_TXDATA = 3'd1,
  parameter logic [2:0]  ADDR_STATUS = 3'd2,
  parameter logic [2:0]  ADDR_SSMASK = 3'd4,
  parameter int unsigned TRDY_BIT    = 5,
  parameter int unsigned RRDY_BIT    = 6,
  parameter logic [15:0] POLL_MAX    = 16'd1000
) (
  input  logic          I_CLK,
  input  logic          I_RESETN,
  input  logic [1:0]    I_REQ,
  input  logic [DW-1:0] I_REQ0_DATA,
  input  logic [DW-1:0] I_REQ1_DATA,
  input  logic [7:0]    I_REQ0_SS,
  input  logic [7:0]    I_REQ1_SS,
  output logic [1:0]    O_ACK,
  output logic [1:0]    O_ERR,
  output logic [DW-1:0] O_RX_DATA,
  output logic          O_BUSY,
  output logic          O_TX_EN,
  output logic [2:0]    O_WADDR,
  output logic [DW-1:0] O_WDATA,
  output logic          O_RX_EN,
  output logic [2:0]    O_RADDR,
  input  logic [DW-1:0] I_RDATA
);

  localparam int unsigned SSW = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned AW  = 3;

  typedef enum logic [3:0] {
    IDLE, SS_WR, TX_POLL, TX_CHK, TX_WR, RX_POLL, RX_CHK, RX_RD, RX_CAP, DONE, ERR
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic [SSW-1:0]  ss_q, ss_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            tx_en_q, tx_en_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            rx_en_q, rx_en_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [1:0]      ack_q, ack_d;
  logic [1:0]      err_q, err_d;
  logic            busy_q, busy_d;
  logic            win;

  // State and registered outputs
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      data_q    <= '0;
      ss_q      <= '0;
      cnt_q     <= '0;
      rx_data_q <= '0;
      tx_en_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rx_en_q   <= 1'b0;
      raddr_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      data_q    <= data_d;
      ss_q      <= ss_d;
      cnt_q     <= cnt_d;
      rx_data_q <= rx_data_d;
      tx_en_q   <= tx_en_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rx_en_q   <= rx_en_d;
      raddr_q   <= raddr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Next state, then strobes decoded from the state being entered so that
  // each bus access lands in the cycle its state is occupied
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    data_d    = data_q;
    ss_d      = ss_q;
    cnt_d     = cnt_q;
    rx_data_d = rx_data_q;
    tx_en_d   = 1'b0;
    waddr_d   = '0;
    wdata_d   = '0;
    rx_en_d   = 1'b0;
    raddr_d   = '0;
    ack_d     = '0;
    err_d     = '0;
    win       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|I_REQ) begin
          // On contention the requester not served last wins
          win    = (I_REQ == 2'b11) ? ~last_q : I_REQ[1];
          gnt_d  = win;
          last_d = win;
          data_d = win ? I_REQ1_DATA : I_REQ0_DATA;
          ss_d   = win ? I_REQ1_SS : I_REQ0_SS;
          cnt_d  = '0;
          state_d = SS_WR;
        end
      end
      SS_WR:   state_d = TX_POLL;
      TX_POLL: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = TX_CHK;
      end
      TX_CHK: begin
        if (I_RDATA[TRDY_BIT]) begin
          cnt_d   = '0;
          state_d = TX_WR;
        end else if (cnt_q == POLL_MAX) begin
          state_d = ERR;
        end else begin
          state_d = TX_POLL;
        end
      end
      TX_WR:   state_d = RX_POLL;
      RX_POLL: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = RX_CHK;
      end
      RX_CHK: begin
        if (I_RDATA[RRDY_BIT]) begin
          cnt_d   = '0;
          state_d = RX_RD;
        end else if (cnt_q == POLL_MAX) begin
          state_d = ERR;
        end else begin
          state_d = RX_POLL;
        end
      end
      RX_RD:   state_d = RX_CAP;
      RX_CAP: begin
        rx_data_d = I_RDATA;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      SS_WR: begin
        tx_en_d = 1'b1;
        waddr_d = ADDR_SSMASK;
        wdata_d = DW'(ss_d);
      end
      TX_POLL, RX_POLL: begin
        rx_en_d = 1'b1;
        raddr_d = ADDR_STATUS;
      end
      TX_WR: begin
        tx_en_d = 1'b1;
        waddr_d = ADDR_TXDATA;
        wdata_d = data_d;
      end
      RX_RD: begin
        rx_en_d = 1'b1;
        raddr_d = ADDR_RXDATA;
      end
      DONE: begin
        tx_en_d       = 1'b1;
        waddr_d       = ADDR_SSMASK;
        ack_d[gnt_d]  = 1'b1;
      end
      ERR: begin
        tx_en_d       = 1'b1;
        waddr_d       = ADDR_SSMASK;
        err_d[gnt_d]  = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign O_ACK     = ack_q;
  assign O_ERR     = err_q;
  assign O_RX_DATA = rx_data_q;
  assign O_BUSY    = busy_q;
  assign O_TX_EN   = tx_en_q;
  assign O_WADDR   = waddr_q;
  assign O_WDATA   = wdata_q;
  assign O_RX_EN   = rx_en_q;
  assign O_RADDR   = raddr_q;

endmodule
